// File: rtl/scroll_scheduler.sv
// Arbitrates the four-character ASCII scroll window between requesters A and B,
// scrolling the granted message for its programmed passes, then blanking the window.
module scroll_scheduler #(
    parameter int MAX_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [31:0]          cyclesPerStrobe,
    input  logic                 reqA,
    input  logic                 reqB,
    input  logic [8*MAX_LEN-1:0] msgA,
    input  logic [8*MAX_LEN-1:0] msgB,
    input  logic [4:0]           lenA,
    input  logic [4:0]           lenB,
    input  logic [3:0]           loopsA,
    input  logic [3:0]           loopsB,
    output logic                 grantA,
    output logic                 grantB,
    output logic                 doneA,
    output logic                 doneB,
    output logic                 busy,
    output logic [7:0]           asciiOne,
    output logic [7:0]           asciiTwo,
    output logic [7:0]           asciiThree,
    output logic [7:0]           asciiFour
);
    localparam int         MW      = 8 * MAX_LEN;
    localparam logic [7:0] BLANK   = 8'hFF;
    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, SCROLL = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    function automatic logic [3:0] fix_loops(input logic [3:0] loops);
        return (loops == 4'd0) ? 4'd1 : loops;
    endfunction

    // Char 0 sits in the most significant used byte of a right-justified string.
    function automatic logic [7:0] char_at(input logic [MW-1:0] m, input logic [4:0] len,
                                           input logic [4:0] idx);
        logic [MW-1:0] sh;
        logic [31:0]   pos;
        pos = 32'd8 * (32'(len) - 32'(idx) - 32'd1);
        sh  = m >> pos;
        return sh[7:0];
    endfunction

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_b_q, last_b_d;
    logic [MW-1:0]   msg_q, msg_d;
    logic [4:0]      len_q, len_d;
    logic [3:0]      loops_q, loops_d;
    logic [4:0]      idx_q, idx_d;
    logic [3:0]      pass_q, pass_d;
    logic [31:0]     tick_q, tick_d;
    logic [2:0]      drain_q, drain_d;
    logic [31:0]     win_q, win_d;
    logic            grant_a_q, grant_a_d, grant_b_q, grant_b_d;
    logic            done_a_q, done_a_d, done_b_q, done_b_d;
    logic            busy_q, busy_d;

    logic            tick_s, any_req_s, pick_b_s, owner_req_s, last_pass_s;
    logic [4:0]      sel_len_s;

    assign tick_s      = (tick_q >= cyclesPerStrobe);
    assign any_req_s   = reqA | reqB;
    assign pick_b_s    = reqB & (~reqA | ~last_b_q);
    assign owner_req_s = owner_q ? reqB : reqA;
    assign sel_len_s   = clamp_len(pick_b_s ? lenB : lenA);
    assign last_pass_s = tick_s && ((idx_q + 5'd1) == len_q)
                         && (({1'b0, pass_q} + 5'd1) == {1'b0, loops_q});

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an owner dropping its request aborts straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = (sel_len_s == 5'd0) ? DRAIN : SCROLL;
                end else begin
                    state_d = IDLE;
                end
            end
            SCROLL: begin
                if (!owner_req_s) begin
                    state_d = DONE;
                end else if (last_pass_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = SCROLL;
                end
            end
            DRAIN: begin
                if (!owner_req_s || (drain_q == 3'd4)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        busy_d    = (state_d != IDLE);
        grant_a_d = busy_d & ~owner_d;
        grant_b_d = busy_d & owner_d;
        done_a_d  = (state_d == DONE) & ~owner_d;
        done_b_d  = (state_d == DONE) & owner_d;
    end

    // Datapath next values: latching, tick generation, window shifting
    always_comb begin
        owner_d  = owner_q;
        last_b_d = last_b_q;
        msg_d    = msg_q;
        len_d    = len_q;
        loops_d  = loops_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        tick_d   = tick_q;
        drain_d  = drain_q;
        win_d    = win_q;
        case (state_q)
            IDLE: begin
                win_d = {4{BLANK}};
                if (any_req_s) begin
                    owner_d = pick_b_s;
                    msg_d   = pick_b_s ? msgB : msgA;
                    len_d   = sel_len_s;
                    loops_d = fix_loops(pick_b_s ? loopsB : loopsA);
                    idx_d   = 5'd0;
                    pass_d  = 4'd0;
                    tick_d  = 32'd0;
                    drain_d = 3'd0;
                end else begin
                    owner_d = owner_q;
                end
            end
            SCROLL, DRAIN: begin
                if (!owner_req_s) begin
                    win_d = {4{BLANK}};
                end else if (tick_s) begin
                    tick_d = 32'd0;
                    if (state_q == SCROLL) begin
                        win_d = {win_q[23:0], char_at(msg_q, len_q, idx_q)};
                        if ((idx_q + 5'd1) == len_q) begin
                            idx_d  = 5'd0;
                            pass_d = pass_q + 4'd1;
                        end else begin
                            idx_d  = idx_q + 5'd1;
                        end
                    end else if (drain_q != 3'd4) begin
                        win_d   = {win_q[23:0], BLANK};
                        drain_d = drain_q + 3'd1;
                    end else begin
                        win_d = win_q;
                    end
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            DONE:    last_b_d = owner_q;
            default: win_d = {4{BLANK}};
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q   <= 1'b0;
            last_b_q  <= 1'b1;
            msg_q     <= '0;
            len_q     <= 5'd0;
            loops_q   <= 4'd1;
            idx_q     <= 5'd0;
            pass_q    <= 4'd0;
            tick_q    <= 32'd0;
            drain_q   <= 3'd0;
            win_q     <= {4{BLANK}};
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            last_b_q  <= last_b_d;
            msg_q     <= msg_d;
            len_q     <= len_d;
            loops_q   <= loops_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            tick_q    <= tick_d;
            drain_q   <= drain_d;
            win_q     <= win_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            busy_q    <= busy_d;
        end
    end

    assign grantA     = grant_a_q;
    assign grantB     = grant_b_q;
    assign doneA      = done_a_q;
    assign doneB      = done_b_q;
    assign busy       = busy_q;
    assign asciiOne   = win_q[31:24];
    assign asciiTwo   = win_q[23:16];
    assign asciiThree = win_q[15:8];
    assign asciiFour  = win_q[7:0];

endmodule

// File: tb/tb_scroll_scheduler.sv
// Bench for scroll_scheduler: directed and random requests checked against a
// character-stream model of the scroll window.
module tb_scroll_scheduler;
    localparam int ML = 16;
    typedef byte unsigned bq_t[$];

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic [31:0]       cps;
    logic              reqA, reqB;
    logic [8*ML-1:0]   msgA, msgB;
    logic [4:0]        lenA, lenB;
    logic [3:0]        loopsA, loopsB;
    logic              grantA, grantB, doneA, doneB, busy;
    logic [7:0]        asciiOne, asciiTwo, asciiThree, asciiFour;
    logic [31:0]       win;

    int checks = 0;
    int errors = 0;

    scroll_scheduler #(.MAX_LEN(ML)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .cyclesPerStrobe(cps),
        .reqA(reqA), .reqB(reqB), .msgA(msgA), .msgB(msgB),
        .lenA(lenA), .lenB(lenB), .loopsA(loopsA), .loopsB(loopsB),
        .grantA(grantA), .grantB(grantB), .doneA(doneA), .doneB(doneB), .busy(busy),
        .asciiOne(asciiOne), .asciiTwo(asciiTwo), .asciiThree(asciiThree), .asciiFour(asciiFour)
    );

    always #5 CLK = ~CLK;
    assign win = {asciiOne, asciiTwo, asciiThree, asciiFour};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic logic [8*ML-1:0] pack(input bq_t q);
        logic [8*ML-1:0] b;
        b = '0;
        foreach (q[i]) b = {b[8*ML-9:0], q[i]};
        return b;
    endfunction

    // Window after k shifts = last four characters of blanks followed by the stream
    function automatic logic [31:0] win_after(input bq_t seq, input int k);
        logic [31:0] w;
        w = 32'hFFFF_FFFF;
        for (int i = 0; i < k; i++) w = {w[23:0], seq[i]};
        return w;
    endfunction

    function automatic logic gr(input bit b);
        return b ? grantB : grantA;
    endfunction

    function automatic logic dn(input bit b);
        return b ? doneB : doneA;
    endfunction

    task automatic set_req(input bit b, input logic v);
        if (b) reqB = v; else reqA = v;
    endtask

    task automatic drive(input bit b, input bq_t m, input int len, input int loops);
        if (b) begin
            msgB = pack(m); lenB = 5'(len); loopsB = 4'(loops); reqB = 1'b1;
        end else begin
            msgA = pack(m); lenA = 5'(len); loopsA = 4'(loops); reqA = 1'b1;
        end
    endtask

    // Follows one request from grant to release; abort_after >= 0 drops req after that many shifts
    task automatic serve(input bit own_b, input bq_t m, input int len_prog, input int loops_prog,
                         input int abort_after, input bit hold);
        bq_t seq;
        int  clen, lp, per, tot, t;
        clen = (len_prog > ML) ? ML : len_prog;
        lp   = (loops_prog == 0) ? 1 : loops_prog;
        per  = int'(cps) + 1;
        for (int p = 0; p < lp; p++)
            for (int i = 0; i < clen; i++) seq.push_back(m[i]);
        for (int i = 0; i < 4; i++) seq.push_back(8'hFF);
        tot = seq.size() * per;
        t = 0;
        while (gr(own_b) !== 1'b1 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk("grant_rise", 32'(gr(own_b)), 32'd1);
        chk("grant_excl", 32'(gr(!own_b)), 32'd0);
        if (!hold) drive(own_b, s2q("zzzz"), $urandom_range(1, 4), $urandom_range(0, 15));
        for (int j = 0; j <= tot; j++) begin
            if (j > 0) @(negedge CLK);
            chk("window", win, win_after(seq, j / per));
            chk("no_early_done", 32'(dn(own_b)), 32'd0);
            chk("grant_held", 32'(gr(own_b)), 32'd1);
            chk("busy_active", 32'(busy), 32'd1);
            if (abort_after >= 0 && j == abort_after * per) begin
                set_req(own_b, 1'b0);
                break;
            end
        end
        @(negedge CLK);
        chk("done_pulse", 32'(dn(own_b)), 32'd1);
        chk("grant_at_done", 32'(gr(own_b)), 32'd1);
        chk("window_blank", win, 32'hFFFF_FFFF);
        if (!hold) set_req(own_b, 1'b0);
        @(negedge CLK);
        chk("done_cleared", 32'(dn(own_b)), 32'd0);
        chk("grants_low", 32'({grantA, grantB}), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t rq;
        bit  rb;
        int  rl, rn;
        RESET_N = 1'b0; cps = 32'd3;
        reqA = 1'b0; reqB = 1'b0; msgA = '0; msgB = '0;
        lenA = 5'd0; lenB = 5'd0; loopsA = 4'd0; loopsB = 4'd0;
        @(negedge CLK);
        chk("reset_window", win, 32'hFFFF_FFFF);
        chk("reset_ctrl", 32'({grantA, grantB, doneA, doneB, busy}), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Basic single pass
        cps = 32'd3;
        drive(1'b0, s2q("0123"), 4, 1);
        serve(1'b0, s2q("0123"), 4, 1, -1, 1'b0);

        // Wrap with several passes
        cps = 32'd1;
        drive(1'b0, s2q("AB"), 2, 3);
        serve(1'b0, s2q("AB"), 2, 3, -1, 1'b0);

        // Edge lengths and pass count
        cps = 32'd2;
        drive(1'b0, s2q("Q"), 0, 2);
        serve(1'b0, s2q("Q"), 0, 2, -1, 1'b0);
        drive(1'b0, s2q("ABCDEFGHIJKLMNOP"), 20, 1);
        serve(1'b0, s2q("ABCDEFGHIJKLMNOP"), 20, 1, -1, 1'b0);
        cps = 32'd0;
        drive(1'b0, s2q("XY"), 2, 0);
        serve(1'b0, s2q("XY"), 2, 0, -1, 1'b0);

        // Abort by A while B waits, then B is served
        cps = 32'd1;
        drive(1'b0, s2q("abcdefghijklmnop"), 16, 1);
        drive(1'b1, s2q("HI"), 2, 1);
        serve(1'b0, s2q("abcdefghijklmnop"), 16, 1, 2, 1'b0);
        serve(1'b1, s2q("HI"), 2, 1, -1, 1'b0);

        // Asynchronous reset in the middle of a scroll
        cps = 32'd0;
        drive(1'b0, s2q("RESETME!"), 8, 2);
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_window", win, 32'hFFFF_FFFF);
        chk("async_ctrl", 32'({grantA, grantB, doneA, doneB, busy}), 32'd0);
        reqA = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("async_no_done", 32'({doneA, doneB}), 32'd0);
        end
        RESET_N = 1'b1;
        @(negedge CLK);

        // Simultaneous requests after reset: A first, then B
        cps = 32'd1;
        drive(1'b0, s2q("0123"), 4, 1);
        drive(1'b1, s2q("AB"), 2, 1);
        serve(1'b0, s2q("0123"), 4, 1, -1, 1'b0);
        serve(1'b1, s2q("AB"), 2, 1, -1, 1'b0);

        // Both held high: grants alternate
        cps = 32'd0;
        drive(1'b0, s2q("01"), 2, 1);
        drive(1'b1, s2q("xyz"), 3, 1);
        serve(1'b0, s2q("01"), 2, 1, -1, 1'b1);
        serve(1'b1, s2q("xyz"), 3, 1, -1, 1'b1);
        serve(1'b0, s2q("01"), 2, 1, -1, 1'b1);
        reqA = 1'b0; reqB = 1'b0;
        @(negedge CLK);
        chk("idle_after_drop", 32'({grantA, grantB, busy}), 32'd0);

        // Random single-requester traffic
        for (int r = 0; r < 8; r++) begin
            rq.delete();
            rb = 1'($urandom_range(0, 1));
            rl = $urandom_range(1, ML);
            rn = $urandom_range(0, 3);
            for (int i = 0; i < rl; i++) rq.push_back(8'($urandom_range(32, 126)));
            cps = 32'($urandom_range(0, 2));
            drive(rb, rq, rl, rn);
            serve(rb, rq, rl, rn, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
